keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
Parametrised, fully synchronous successor to the team's numeric-keypad digit-entry block. It synchronises and debounces a 12-key pad (digits 0-9, BACKSPACE, ENTER) and edits an N-digit BCD buffer calculator-style. On ENTER it converts the buffer to binary sequentially and drives active-low 7-segment patterns for every digit. It sits between the board key inputs and any consumer of a typed number.

Parameters:
NUM_DIGITS, 4, digits in the entry buffer (1..8).
DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples required before a key pattern is accepted (>=1).
VALUE_W, 14, binary result width; must hold 10^NUM_DIGITS-1, otherwise the result is truncated modulo 2^VALUE_W.
CLEAR_ON_ENTER, 0, 1 = clear buffer after a conversion completes.

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
keys  in  12  raw key levels, active-high; [9:0] = digits 0-9, [10] = BACKSPACE, [11] = ENTER
digits  out  4*NUM_DIGITS  BCD buffer; nibble 0 = least-significant digit
digit_count  out  $clog2(NUM_DIGITS+1)  number of digits entered
value  out  VALUE_W  binary value of last conversion
value_valid  out  1  one-cycle pulse when value updates
busy  out  1  high while in CONVERT
overflow  out  1  one-cycle pulse: digit pressed while buffer full
key_error  out  1  one-cycle pulse: accepted pattern not one-hot
seg  out  7*NUM_DIGITS  active-low segments per digit, bit order a..g MSB-first per 7-bit group

Behaviour:
- Reset (async, any state): all outputs 0, except seg = all digits blank (1111111), then digit 0 shows "0" (0000001). State IDLE, synchroniser and counters cleared.
- keys pass a 2-flop synchroniser; everything below uses the synchronised vector ks.
- FSM: IDLE, DEBOUNCE, WAIT_RELEASE, CONVERT.
- IDLE: ks != 0 -> latch pattern, counter = 1, go to DEBOUNCE.
- DEBOUNCE: ks differs from latched pattern -> IDLE (nothing applied). Otherwise increment counter. When counter reaches DEBOUNCE_CYCLES, apply the action this cycle:
  - Pattern not one-hot: key_error pulse, go to WAIT_RELEASE.
  - Digit d, count < NUM_DIGITS: shift buffer up one nibble, nibble 0 = d, count+1, go to WAIT_RELEASE.
  - Digit d, count == NUM_DIGITS: buffer unchanged, overflow pulse, go to WAIT_RELEASE.
  - BACKSPACE: shift buffer down one nibble, top nibble = 0, count-1 (saturates at 0, no pulse), go to WAIT_RELEASE.
  - ENTER: acc = 0, index = NUM_DIGITS-1, go to CONVERT.
- CONVERT: busy = 1; each cycle acc = acc*10 + digits[index], index-1. Runs exactly NUM_DIGITS cycles (unentered nibbles are 0). On the cycle after the last step: value = acc, value_valid pulse, buffer and count cleared if CLEAR_ON_ENTER, go to WAIT_RELEASE. value_valid is asserted NUM_DIGITS+1 cycles after the ENTER action cycle. Keys are ignored during CONVERT.
- WAIT_RELEASE: stay until ks == 0, then go to IDLE. Holding a key gives exactly one action, with no auto-repeat.
- Arithmetic: acc is VALUE_W bits wide, multiply by 10 as (acc<<3)+(acc<<1), wrap modulo 2^VALUE_W.
- Display: position i with i >= count is blank, except position 0, which shows 0 when count == 0. Nibbles 10-15 cannot occur; the decoder shows blank for them.
- Reset asserted mid-DEBOUNCE or mid-CONVERT aborts immediately. No value_valid is produced.

Decomposition:
- Package keypad_pkg: key index constants (KEY_BS = 10, KEY_ENTER = 11), state enum, 7-bit active-low segment constants for 0-9 and SEG_BLANK.
- Sub-module seg7_decoder: combinational BCD plus blank-enable to active-low segments, instantiated NUM_DIGITS times via generate.

Test Plan:
Bench uses NUM_DIGITS = 4, DEBOUNCE_CYCLES = 4, CLEAR_ON_ENTER = 0.
1. Press 1, 2, 3, 4, then ENTER (each key held 10 cycles, released 10) -> digits = 0x1234, count = 4, value = 1234 with one value_valid pulse 5 cycles after the ENTER action; seg[6:0] = 1001100 ("4").
2. Press 9 four times, then 5 -> fifth press gives one overflow pulse, digits stay 0x9999; ENTER -> value = 9999.
3. Type 7, 8, then BACKSPACE -> digits = 0x0007, count = 1, positions 1-3 blank; BACKSPACE twice more -> count = 0, position 0 shows "0", no pulses.
4. Key 5 glitching for 2 cycles, then released -> no change and no pulses; keys 3 and 4 held together -> one key_error pulse, buffer unchanged.
5. Key 6 held 200 cycles -> exactly one digit entered; a press during CONVERT is ignored and busy is high for 4 cycles.
6. Reset asserted mid-CONVERT after typing 42 -> all outputs at reset values immediately, with no value_valid.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad digit-entry block: key indices, FSM
// states, active-low 7-segment glyphs and small pattern helpers.
package keypad_pkg;

  localparam int NUM_KEYS  = 12;
  localparam int KEY_BS    = 10;
  localparam int KEY_ENTER = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_WAIT_RELEASE,
    ST_CONVERT
  } state_e;

  // Segment order a..g, MSB first, 0 = lit.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] p);
    return (p != '0) && ((p & (p - 12'd1)) == '0);
  endfunction

  function automatic logic [3:0] key_index(input logic [NUM_KEYS-1:0] p);
    logic [3:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (p[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_entry_seg7_decoder.sv
// BCD digit to active-low 7-segment pattern; blank_i or a non-decimal
// nibble turns every segment off.
module seg7_decoder
  import keypad_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Debounced 12-key pad editing an N-digit BCD buffer; ENTER converts the
// buffer to binary one digit per cycle and every digit drives a 7-seg glyph.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int VALUE_W         = 14,
  parameter int CLEAR_ON_ENTER  = 0
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [NUM_KEYS-1:0]               keys_i,
  output logic [4*NUM_DIGITS-1:0]           digits_o,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count_o,
  output logic [VALUE_W-1:0]                value_o,
  output logic                              value_valid_o,
  output logic                              busy_o,
  output logic                              overflow_o,
  output logic                              key_error_o,
  output logic [7*NUM_DIGITS-1:0]           seg_o
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_KEYS-1:0]         sync_q, ks_q;
  state_e                      state_q, state_d;
  logic [NUM_KEYS-1:0]         pat_q, pat_d;
  logic [DW-1:0]               dcnt_q, dcnt_d;
  logic [NUM_DIGITS-1:0][3:0]  buf_q, buf_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [VALUE_W-1:0]          acc_q, acc_d, value_q, value_d, acc_next;
  logic [IW-1:0]               idx_q, idx_d;
  logic                        vv_q, vv_d, ovf_q, ovf_d, kerr_q, kerr_d;
  logic                        match, deb_done, last_step;

  assign match     = (ks_q == pat_q);
  // The IDLE sample that latched the pattern counts as the first one.
  assign deb_done  = match && (int'(dcnt_q) + 1 >= DEBOUNCE_CYCLES);
  assign last_step = (idx_q == '0);
  assign acc_next  = (acc_q << 3) + (acc_q << 1) + VALUE_W'(buf_q[idx_q]);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
      ks_q   <= '0;
    end else begin
      sync_q <= keys_i;
      ks_q   <= sync_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:         if (ks_q != '0) state_d = ST_DEBOUNCE;
      ST_DEBOUNCE: begin
        if (!match)        state_d = ST_IDLE;
        else if (deb_done) state_d = (is_onehot(pat_q) && pat_q[KEY_ENTER]) ? ST_CONVERT
                                                                             : ST_WAIT_RELEASE;
      end
      ST_CONVERT:      if (last_step) state_d = ST_WAIT_RELEASE;
      ST_WAIT_RELEASE: if (ks_q == '0) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pat_d   = pat_q;
    dcnt_d  = dcnt_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    value_d = value_q;
    vv_d    = 1'b0;
    ovf_d   = 1'b0;
    kerr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ks_q != '0) begin
          pat_d  = ks_q;
          dcnt_d = DW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (match) begin
          dcnt_d = dcnt_q + DW'(1);
          if (deb_done) begin
            if (!is_onehot(pat_q)) begin
              kerr_d = 1'b1;
            end else if (pat_q[KEY_ENTER]) begin
              acc_d = '0;
              idx_d = IW'(NUM_DIGITS - 1);
            end else if (pat_q[KEY_BS]) begin
              for (int i = 0; i < NUM_DIGITS - 1; i++) buf_d[i] = buf_q[i+1];
              buf_d[NUM_DIGITS-1] = '0;
              if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end else if (cnt_q == CW'(NUM_DIGITS)) begin
              ovf_d = 1'b1;
            end else begin
              for (int i = 1; i < NUM_DIGITS; i++) buf_d[i] = buf_q[i-1];
              buf_d[0] = key_index(pat_q);
              cnt_d    = cnt_q + CW'(1);
            end
          end
        end
      end
      ST_CONVERT: begin
        acc_d = acc_next;
        idx_d = idx_q - IW'(1);
        if (last_step) begin
          value_d = acc_next;
          vv_d    = 1'b1;
          if (CLEAR_ON_ENTER != 0) begin
            buf_d = '0;
            cnt_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pat_q   <= '0;
      dcnt_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      value_q <= '0;
      vv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      kerr_q  <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      dcnt_q  <= dcnt_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      vv_q    <= vv_d;
      ovf_q   <= ovf_d;
      kerr_q  <= kerr_d;
    end
  end

  always_comb begin
    busy_o        = (state_q == ST_CONVERT);
    digits_o      = buf_q;
    digit_count_o = cnt_q;
    value_o       = value_q;
    value_valid_o = vv_q;
    overflow_o    = ovf_q;
    key_error_o   = kerr_q;
  end

  // Position 0 always shows something: "0" for an empty buffer.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
    logic [3:0] nib;
    logic       blank;
    if (gi == 0) begin : g_lsd
      assign nib   = (cnt_q == '0) ? 4'd0 : buf_q[0];
      assign blank = 1'b0;
    end else begin : g_upper
      assign nib   = buf_q[gi];
      assign blank = (gi >= int'(cnt_q));
    end
    seg7_decoder u_dec (
      .bcd_i   (nib),
      .blank_i (blank),
      .seg_o   (seg_o[7*gi +: 7])
    );
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: directed scenarios plus random key
// sequences compared against a decimal-arithmetic model of the entry buffer.
module tb_keypad_entry;

  logic        clk, reset;
  logic [11:0] keys;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic [13:0] value;
  logic        value_valid, busy, overflow, key_error;
  logic [27:0] seg;

  keypad_entry #(
    .NUM_DIGITS(4), .DEBOUNCE_CYCLES(4), .VALUE_W(14), .CLEAR_ON_ENTER(0)
  ) dut (
    .clk_i(clk), .reset_i(reset), .keys_i(keys),
    .digits_o(digits), .digit_count_o(digit_count), .value_o(value),
    .value_valid_o(value_valid), .busy_o(busy), .overflow_o(overflow),
    .key_error_o(key_error), .seg_o(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] SEGTAB [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  localparam logic [27:0] SEG_RST = {21'h1FFFFF, 7'b0000001};
  localparam logic [11:0] K_BS = 12'h400;
  localparam logic [11:0] K_EN = 12'h800;

  int checks = 0, errors = 0;
  // model: the typed number as an integer, its digit count, last result
  int m_num = 0, m_cnt = 0, m_val = 0;
  int exp_vv = 0, exp_ovf = 0, exp_kerr = 0;
  // observed pulse statistics
  int cyc = 0, vv_n = 0, ovf_n = 0, kerr_n = 0, busy_n = 0;
  int vv_cyc = 0, busy_rise = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (value_valid) begin vv_n++; vv_cyc = cyc; end
    if (overflow) ovf_n++;
    if (key_error) kerr_n++;
    if (busy) begin
      busy_n++;
      if (!busy_prev) busy_rise = cyc;
    end
    busy_prev = busy;
  end

  function automatic logic [15:0] exp_digits(input int n);
    logic [15:0] r;
    int v;
    v = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [27:0] exp_seg(input int n, input int c);
    logic [27:0] s;
    int v;
    v = n;
    for (int i = 0; i < 4; i++) begin
      if (i >= c && i != 0) s[7*i +: 7] = 7'h7F;
      else                  s[7*i +: 7] = SEGTAB[v % 10];
      v = v / 10;
    end
    return s;
  endfunction

  function automatic void model_key(input logic [11:0] p);
    int d;
    if ($countones(p) != 1) exp_kerr++;
    else if (p[11]) begin m_val = m_num % 16384; exp_vv++; end
    else if (p[10]) begin
      if (m_cnt > 0) begin m_num = m_num / 10; m_cnt--; end
    end else if (m_cnt == 4) exp_ovf++;
    else begin
      d = 0;
      for (int i = 0; i < 10; i++) if (p[i]) d = i;
      m_num = m_num * 10 + d;
      m_cnt++;
    end
  endfunction

  task automatic press(input logic [11:0] p, input int hold, input int rel);
    keys = p;
    repeat (hold) @(negedge clk);
    keys = '0;
    repeat (rel) @(negedge clk);
    model_key(p);
  endtask

  task automatic test_reset();
    keys = '0; reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (digits !== 16'h0) begin errors++; $display("FAIL reset_digits: got %h exp 0", digits); end
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", digit_count); end
    checks++; if ({value_valid, busy, overflow, key_error} !== 4'b0 || value !== 14'd0)
      begin errors++; $display("FAIL reset_flags: got v=%0d flags=%b exp 0", value, {value_valid, busy, overflow, key_error}); end
    checks++; if (seg !== SEG_RST) begin errors++; $display("FAIL reset_seg: got %h exp %h", seg, SEG_RST); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_entry();
    int b0, v0;
    for (int d = 1; d <= 4; d++) press(12'(1) << d, 10, 10);
    checks++; if (digits !== exp_digits(m_num)) begin errors++; $display("FAIL entry_digits: got %h exp %h", digits, exp_digits(m_num)); end
    checks++; if (digit_count !== 3'(m_cnt)) begin errors++; $display("FAIL entry_count: got %0d exp %0d", digit_count, m_cnt); end
    b0 = busy_n; v0 = vv_n;
    press(K_EN, 10, 10);
    checks++; if (value !== 14'(m_val)) begin errors++; $display("FAIL entry_value: got %0d exp %0d", value, m_val); end
    checks++; if (vv_n - v0 != 1) begin errors++; $display("FAIL entry_vv_pulses: got %0d exp 1", vv_n - v0); end
    checks++; if (busy_n - b0 != 4) begin errors++; $display("FAIL entry_busy_cycles: got %0d exp 4", busy_n - b0); end
    checks++; if (vv_cyc - busy_rise != 4) begin errors++; $display("FAIL entry_vv_latency: got %0d exp 4", vv_cyc - busy_rise); end
    checks++; if (seg[6:0] !== 7'b1001100) begin errors++; $display("FAIL entry_seg0: got %b exp 1001100", seg[6:0]); end
    checks++; if (seg !== exp_seg(m_num, m_cnt)) begin errors++; $display("FAIL entry_seg: got %h exp %h", seg, exp_seg(m_num, m_cnt)); end
  endtask

  task automatic test_overflow();
    int o0;
    repeat (4) press(K_BS, 10, 10);
    repeat (4) press(12'(1) << 9, 10, 10);
    o0 = ovf_n;
    press(12'(1) << 5, 10, 10);
    checks++; if (ovf_n - o0 != 1) begin errors++; $display("FAIL ovf_pulses: got %0d exp 1", ovf_n - o0); end
    checks++; if (digits !== 16'h9999) begin errors++; $display("FAIL ovf_digits: got %h exp 9999", digits); end
    press(K_EN, 10, 10);
    checks++; if (value !== 14'd9999) begin errors++; $display("FAIL ovf_value: got %0d exp 9999", value); end
    checks++; if (ovf_n !== exp_ovf) begin errors++; $display("FAIL ovf_total: got %0d exp %0d", ovf_n, exp_ovf); end
  endtask

  task automatic test_backspace();
    int v0, o0, k0;
    repeat (4) press(K_BS, 10, 10);
    press(12'(1) << 7, 10, 10);
    press(12'(1) << 8, 10, 10);
    v0 = vv_n; o0 = ovf_n; k0 = kerr_n;
    press(K_BS, 10, 10);
    checks++; if (digits !== 16'h0007) begin errors++; $display("FAIL bs_digits: got %h exp 0007", digits); end
    checks++; if (digit_count !== 3'd1) begin errors++; $display("FAIL bs_count: got %0d exp 1", digit_count); end
    checks++; if (seg[27:7] !== 21'h1FFFFF) begin errors++; $display("FAIL bs_blank: got %h exp 1fffff", seg[27:7]); end
    press(K_BS, 10, 10);
    press(K_BS, 10, 10);
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL bs_count0: got %0d exp 0", digit_count); end
    checks++; if (seg !== SEG_RST) begin errors++; $display("FAIL bs_seg0: got %h exp %h", seg, SEG_RST); end
    checks++; if (vv_n != v0 || ovf_n != o0 || kerr_n != k0)
      begin errors++; $display("FAIL bs_pulses: got %0d/%0d/%0d exp 0/0/0", vv_n - v0, ovf_n - o0, kerr_n - k0); end
  endtask

  task automatic test_glitch_error();
    int o0, k0;
    o0 = ovf_n; k0 = kerr_n;
    keys = 12'(1) << 5;
    repeat (2) @(negedge clk);
    keys = '0;
    repeat (10) @(negedge clk);
    checks++; if (digits !== exp_digits(m_num) || digit_count !== 3'(m_cnt))
      begin errors++; $display("FAIL glitch_buffer: got %h/%0d exp %h/%0d", digits, digit_count, exp_digits(m_num), m_cnt); end
    checks++; if (ovf_n != o0 || kerr_n != k0) begin errors++; $display("FAIL glitch_pulses: got %0d/%0d exp 0/0", ovf_n - o0, kerr_n - k0); end
    press(12'h018, 10, 10);
    checks++; if (kerr_n - k0 != 1) begin errors++; $display("FAIL keyerr_pulses: got %0d exp 1", kerr_n - k0); end
    checks++; if (digits !== exp_digits(m_num)) begin errors++; $display("FAIL keyerr_digits: got %h exp %h", digits, exp_digits(m_num)); end
  endtask

  task automatic test_hold_convert();
    int b0, v0;
    press(12'(1) << 6, 200, 10);
    checks++; if (digits !== exp_digits(m_num) || digit_count !== 3'(m_cnt))
      begin errors++; $display("FAIL hold_buffer: got %h/%0d exp %h/%0d", digits, digit_count, exp_digits(m_num), m_cnt); end
    b0 = busy_n; v0 = vv_n;
    keys = K_EN;
    for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
    checks++; if (!busy) begin errors++; $display("FAIL conv_busy_timeout: got 0 exp 1"); end
    keys = 12'(1) << 5;
    repeat (10) @(negedge clk);
    keys = '0;
    repeat (10) @(negedge clk);
    model_key(K_EN);
    checks++; if (busy_n - b0 != 4) begin errors++; $display("FAIL conv_busy_cycles: got %0d exp 4", busy_n - b0); end
    checks++; if (vv_n - v0 != 1 || value !== 14'(m_val))
      begin errors++; $display("FAIL conv_value: got %0d (%0d pulses) exp %0d (1)", value, vv_n - v0, m_val); end
    checks++; if (digits !== exp_digits(m_num) || digit_count !== 3'(m_cnt))
      begin errors++; $display("FAIL conv_ignored_key: got %h/%0d exp %h/%0d", digits, digit_count, exp_digits(m_num), m_cnt); end
  endtask

  task automatic test_random();
    logic [11:0] p;
    int r, a, b;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 19);
      if (r < 14)      p = 12'(1) << $urandom_range(0, 9);
      else if (r < 17) p = K_BS;
      else if (r < 19) p = K_EN;
      else begin
        a = $urandom_range(0, 11);
        b = (a + 1 + $urandom_range(0, 10)) % 12;
        p = (12'(1) << a) | (12'(1) << b);
      end
      press(p, $urandom_range(8, 15), $urandom_range(6, 12));
      checks++; if (digits !== exp_digits(m_num) || digit_count !== 3'(m_cnt))
        begin errors++; $display("FAIL rand_buffer[%0d]: got %h/%0d exp %h/%0d", n, digits, digit_count, exp_digits(m_num), m_cnt); end
      checks++; if (value !== 14'(m_val)) begin errors++; $display("FAIL rand_value[%0d]: got %0d exp %0d", n, value, m_val); end
      checks++; if (seg !== exp_seg(m_num, m_cnt)) begin errors++; $display("FAIL rand_seg[%0d]: got %h exp %h", n, seg, exp_seg(m_num, m_cnt)); end
      checks++; if (vv_n != exp_vv || ovf_n != exp_ovf || kerr_n != exp_kerr)
        begin errors++; $display("FAIL rand_pulses[%0d]: got %0d/%0d/%0d exp %0d/%0d/%0d", n, vv_n, ovf_n, kerr_n, exp_vv, exp_ovf, exp_kerr); end
    end
  endtask

  task automatic test_reset_mid_convert();
    int v0;
    repeat (4) press(K_BS, 10, 10);
    press(12'(1) << 4, 10, 10);
    press(12'(1) << 2, 10, 10);
    v0 = vv_n;
    keys = K_EN;
    for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
    checks++; if (!busy) begin errors++; $display("FAIL rmc_busy_timeout: got 0 exp 1"); end
    @(negedge clk);
    reset = 1'b1;
    keys = '0;
    #1;
    m_num = 0; m_cnt = 0; m_val = 0;
    checks++; if (digits !== 16'h0 || digit_count !== 3'd0)
      begin errors++; $display("FAIL rmc_buffer: got %h/%0d exp 0/0", digits, digit_count); end
    checks++; if ({value_valid, busy, overflow, key_error} !== 4'b0 || value !== 14'd0)
      begin errors++; $display("FAIL rmc_flags: got v=%0d flags=%b exp 0", value, {value_valid, busy, overflow, key_error}); end
    checks++; if (seg !== SEG_RST) begin errors++; $display("FAIL rmc_seg: got %h exp %h", seg, SEG_RST); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (vv_n != v0 || value !== 14'd0) begin errors++; $display("FAIL rmc_no_valid: got %0d pulses v=%0d exp 0", vv_n - v0, value); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    keys = '0;
    reset = 1'b1;
    test_reset();
    test_entry();
    test_overflow();
    test_backspace();
    test_glitch_error();
    test_hold_convert();
    test_random();
    test_reset_mid_convert();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
